mha_matmul_scheduler: RTL and testbench
=======================================

Name: mha_matmul_scheduler

Overview:
- Time-multiplexes one shared multi_matmul_wrapper (the Qn·KnT engine) across NUM_HEADS bridge-buffer instances, one instance per attention head.
- Selects a ready head round-robin and drives the matmul's local reset, enable and accumulator-reset controls.
- Counts completed output tiles, waits for the systolic array to drain, then signals head completion.
- Sits between the bridge-buffer banks and the shared matmul. Its grant/index drives the operand mux in front of input_w/input_n.

Parameters:
- NUM_HEADS, 4, number of buffer instances/heads competing for the matmul
- TILES_PER_HEAD, 8, acc_done_wrap pulses that complete one head's score matrix
- RST_CYCLES, 2, cycles mm_rst_n is held low before each head's run (≥1)
- IDX_W, $clog2(NUM_HEADS) (min 1), width of sel_idx
- CNT_W, $clog2(TILES_PER_HEAD+1), width of tile_cnt

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- head_ready  in  NUM_HEADS  level; bit i = buffer i holds a full operand set
- acc_done_wrap  in  1  matmul pulse: one output tile accumulated
- systolic_finish_wrap  in  1  matmul pulse/level: array fully drained
- head_grant  out  NUM_HEADS  one-hot owner of the matmul; all-zero when none
- sel_idx  out  IDX_W  binary index of the granted head (operand/result mux select)
- mm_rst_n  out  1  local active-low reset to the matmul
- mm_en  out  1  matmul enable
- mm_reset_acc  out  1  one-cycle accumulator clear
- head_done  out  NUM_HEADS  one-cycle pulse, bit i = head i finished
- tile_cnt  out  CNT_W  tiles completed for the current head
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 sampled at posedge), all registered:
  - head_grant=0, sel_idx=0, mm_rst_n=0, mm_en=0, mm_reset_acc=0, head_done=0, tile_cnt=0, busy=0
  - state=IDLE, round-robin pointer=0
- Reset mid-operation aborts the current head. No head_done is issued for it.
- FSM states: IDLE, RESET, RUN, DRAIN, DONE.
- IDLE:
  - mm_rst_n=1, mm_en=0.
  - If any head_ready bit is set, choose the first set bit at or after the pointer, wrapping modulo NUM_HEADS.
  - Next cycle: head_grant/sel_idx valid, state=RESET, internal counter=0.
  - head_ready is sampled only in IDLE. Later changes are ignored until the next arbitration.
- RESET:
  - mm_rst_n=0 for exactly RST_CYCLES cycles, mm_en=0.
  - Then state=RUN and tile_cnt=0.
- RUN:
  - mm_rst_n=1, mm_en=1.
  - Each cycle acc_done_wrap=1: tile_cnt increments, and mm_reset_acc=1 on the following cycle only.
  - On the TILES_PER_HEAD-th pulse: mm_en drops the next cycle and state=DRAIN.
  - If systolic_finish_wrap is also high in that same cycle, go directly to DONE.
  - tile_cnt saturates at TILES_PER_HEAD.
- DRAIN:
  - mm_en=0. Any acc_done_wrap is ignored and does not change tile_cnt.
  - On systolic_finish_wrap=1, state=DONE.
- DONE (one cycle):
  - head_done[granted]=1, head_grant cleared to 0.
  - Pointer = granted index + 1, mod NUM_HEADS.
  - Next state IDLE. Re-arbitration happens the following cycle, so there is a 1-cycle gap minimum between heads.
- A systolic_finish_wrap arriving in IDLE or RESET is ignored.
- Invariants:
  - mm_en is never high while mm_rst_n=0.
  - head_grant is never multi-hot.

Decomposition:
- Package mha_sched_pkg:
  - state enum type sched_state_t
  - default NUM_HEADS / TILES_PER_HEAD / RST_CYCLES constants, derived from the existing self-attention package constants so tile count matches the Qn·KnT geometry
- Sub-module rr_arbiter:
  - parameterised NUM_HEADS
  - inputs: request vector, pointer
  - outputs: one-hot grant, index, valid
  - combinational, instantiated once

Test Plan:
- Single head, defaults:
  - Stimulus: head_ready=4'b0001; 8 acc_done pulses spaced 5 cycles apart; systolic_finish 3 cycles after the last pulse.
  - Response: grant=0001; mm_rst_n low for 2 cycles; tile_cnt reaches 8; mm_reset_acc pulses 8 times; head_done=0001 once; busy falls.
- Round-robin fairness:
  - Stimulus: head_ready=4'b1111 held throughout.
  - Response: grant order 0001, 0010, 0100, 1000, 0001; exactly one head_done per head, in the same order.
- Skip and wrap:
  - Stimulus: pointer=2 after serving head 1; head_ready=4'b0011.
  - Response: head 0 is granted next, sel_idx=0.
- Simultaneous finish:
  - Stimulus: 8th acc_done_wrap coincides with systolic_finish_wrap.
  - Response: DRAIN is skipped; head_done occurs the next cycle.
- Spurious pulses:
  - Stimulus: acc_done_wrap in DRAIN; systolic_finish_wrap in IDLE.
  - Response: tile_cnt stays 8; no state change; no head_done.
- Reset mid-RUN:
  - Stimulus: rst_n=0 for 1 cycle at tile_cnt=3.
  - Response: all outputs at reset values the next cycle; no head_done; the next grant starts from head 0.

Source files
------------

// File: rtl/mha_matmul_scheduler_pkg.sv
// Shared types and default geometry for the multi-head matmul scheduler.
// Tile count follows the Qn*KnT score matrix tiled onto the systolic array.
package mha_sched_pkg;

   localparam int ATTN_HEADS  = 4;
   localparam int ATTN_Q_ROWS = 32;
   localparam int ATTN_K_ROWS = 16;
   localparam int SA_DIM      = 8;

   localparam int NUM_HEADS_D      = ATTN_HEADS;
   localparam int TILES_PER_HEAD_D = (ATTN_Q_ROWS / SA_DIM) * (ATTN_K_ROWS / SA_DIM);
   localparam int RST_CYCLES_D     = 2;

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      RUN,
      DRAIN,
      DONE
   } sched_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mha_matmul_scheduler_if.sv
// Scheduler <-> bridge-buffer banks and shared matmul control bundle.
interface mha_matmul_scheduler_if
   import mha_sched_pkg::*;
#(
   parameter int NUM_HEADS = NUM_HEADS_D,
   parameter int IDX_W     = idx_w(NUM_HEADS),
   parameter int CNT_W     = $clog2(TILES_PER_HEAD_D + 1)
);

   logic [NUM_HEADS-1:0] head_ready;
   logic                 acc_done_wrap;
   logic                 systolic_finish_wrap;
   logic [NUM_HEADS-1:0] head_grant;
   logic [IDX_W-1:0]     sel_idx;
   logic                 mm_rst_n;
   logic                 mm_en;
   logic                 mm_reset_acc;
   logic [NUM_HEADS-1:0] head_done;
   logic [CNT_W-1:0]     tile_cnt;
   logic                 busy;

   modport master (
      input  head_ready, acc_done_wrap, systolic_finish_wrap,
      output head_grant, sel_idx, mm_rst_n, mm_en, mm_reset_acc,
      output head_done, tile_cnt, busy
   );

   modport slave (
      output head_ready, acc_done_wrap, systolic_finish_wrap,
      input  head_grant, sel_idx, mm_rst_n, mm_en, mm_reset_acc,
      input  head_done, tile_cnt, busy
   );

endinterface

// File: rtl/mha_matmul_scheduler_rr_arbiter.sv
// Round-robin pick: first requesting head at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_HEADS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_HEADS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_HEADS-1:0] grant,
   output logic [IDX_W-1:0]     idx,
   output logic                 valid
);

   always_comb begin
      int j;
      logic [IDX_W-1:0] jx;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      jx    = '0;
      for (int i = 0; i < NUM_HEADS; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_HEADS) j = j - NUM_HEADS;
         jx = IDX_W'(j);
         if (!valid && req[jx]) begin
            valid     = 1'b1;
            grant[jx] = 1'b1;
            idx       = jx;
         end
      end
   end

endmodule

// File: rtl/mha_matmul_scheduler.sv
// Time-multiplexes one shared matmul engine across NUM_HEADS head buffers.
module mha_matmul_scheduler
   import mha_sched_pkg::*;
#(
   parameter int NUM_HEADS      = NUM_HEADS_D,
   parameter int TILES_PER_HEAD = TILES_PER_HEAD_D,
   parameter int RST_CYCLES     = RST_CYCLES_D,
   parameter int IDX_W          = idx_w(NUM_HEADS),
   parameter int CNT_W          = $clog2(TILES_PER_HEAD + 1)
) (
   input logic                   clk,
   input logic                   rst_n,
   mha_matmul_scheduler_if.master bus
);

   localparam int RC_W = $clog2(RST_CYCLES + 1);

   sched_state_t         state;
   logic [IDX_W-1:0]     ptr;
   logic [RC_W-1:0]      rcnt;
   logic [NUM_HEADS-1:0] arb_grant;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_valid;
   logic                 last_tile;
   logic                 fin_go;
   logic [IDX_W-1:0]     ptr_nxt;

   rr_arbiter #(
      .NUM_HEADS(NUM_HEADS),
      .IDX_W    (IDX_W)
   ) u_arb (
      .req  (bus.head_ready),
      .ptr  (ptr),
      .grant(arb_grant),
      .idx  (arb_idx),
      .valid(arb_valid)
   );

   assign last_tile = bus.acc_done_wrap &&
                      (bus.tile_cnt == CNT_W'(TILES_PER_HEAD - 1));

   // A finish coinciding with the last tile skips DRAIN entirely.
   assign fin_go = bus.systolic_finish_wrap &&
                   ((state == DRAIN) || (state == RUN && last_tile));

   assign ptr_nxt = (bus.sel_idx == IDX_W'(NUM_HEADS - 1)) ?
                    '0 : bus.sel_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= IDLE;
         ptr              <= '0;
         rcnt             <= '0;
         bus.head_grant   <= '0;
         bus.sel_idx      <= '0;
         bus.mm_rst_n     <= 1'b0;
         bus.mm_en        <= 1'b0;
         bus.mm_reset_acc <= 1'b0;
         bus.head_done    <= '0;
         bus.tile_cnt     <= '0;
         bus.busy         <= 1'b0;
      end else begin
         bus.mm_reset_acc <= 1'b0;
         bus.head_done    <= '0;
         unique case (state)
            IDLE: begin
               bus.mm_rst_n <= 1'b1;
               bus.mm_en    <= 1'b0;
               bus.busy     <= arb_valid;
               if (arb_valid) begin
                  state          <= RESET;
                  bus.head_grant <= arb_grant;
                  bus.sel_idx    <= arb_idx;
                  bus.mm_rst_n   <= 1'b0;
                  rcnt           <= '0;
               end
            end
            RESET: begin
               if (rcnt == RC_W'(RST_CYCLES - 1)) begin
                  state        <= RUN;
                  bus.mm_rst_n <= 1'b1;
                  bus.mm_en    <= 1'b1;
                  bus.tile_cnt <= '0;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            RUN: begin
               bus.mm_reset_acc <= bus.acc_done_wrap;
               if (bus.acc_done_wrap &&
                   bus.tile_cnt != CNT_W'(TILES_PER_HEAD))
                  bus.tile_cnt <= bus.tile_cnt + 1'b1;
               if (last_tile) begin
                  bus.mm_en <= 1'b0;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               bus.mm_en <= 1'b0;
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (fin_go) begin
            state          <= DONE;
            bus.head_done  <= bus.head_grant;
            bus.head_grant <= '0;
            ptr            <= ptr_nxt;
         end
      end
   end

endmodule

// File: tb/tb_mha_matmul_scheduler.sv
// Randomized self-checking bench for mha_matmul_scheduler.
module tb_mha_matmul_scheduler;
   import mha_sched_pkg::*;

   localparam int N  = NUM_HEADS_D;
   localparam int T  = TILES_PER_HEAD_D;
   localparam int R  = RST_CYCLES_D;
   localparam int IW = idx_w(N);
   localparam int CW = $clog2(T + 1);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mha_matmul_scheduler_if #(.NUM_HEADS(N), .IDX_W(IW), .CNT_W(CW)) bus ();

   mha_matmul_scheduler #(
      .NUM_HEADS     (N),
      .TILES_PER_HEAD(T),
      .RST_CYCLES    (R),
      .IDX_W         (IW),
      .CNT_W         (CW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int racc_cnt = 0;
   int done_cnt = 0;
   int inv_bad  = 0;
   int mdl_ptr  = 0;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (bus.mm_reset_acc === 1'b1) racc_cnt++;
      if (bus.head_done !== '0) done_cnt++;
      if (bus.mm_en === 1'b1 && bus.mm_rst_n === 1'b0) inv_bad++;
      if ($countones(bus.head_grant) > 1) inv_bad++;
   endtask

   function automatic int exp_head(input logic [N-1:0] rdy, input int p);
      for (int i = 0; i < N; i++)
         if (rdy[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      bus.head_ready = '0;
      bus.acc_done_wrap = 1'b0;
      bus.systolic_finish_wrap = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      mdl_ptr = 0;
   endtask

   task automatic run_head(
      input  int gmin, input int gmax, input int drain_gap,
      input  bit simul, input bit spurious, input bit clr_ready,
      input  bit fin_in_reset,
      output logic [N-1:0] g, output logic [IW-1:0] si,
      output int rst_low, output int tiles, output int racc,
      output logic [N-1:0] done_v, output int lat,
      output bit en_bad, output bit seq_bad, output bit to);
      int w;
      int r0;
      to = 1'b0; en_bad = 1'b0; seq_bad = 1'b0;
      g = '0; si = '0; rst_low = 0; tiles = 0; racc = 0;
      done_v = '0; lat = 0;
      r0 = racc_cnt;
      w = 0;
      while (bus.head_grant === '0 && w < 10) begin
         cyc();
         w++;
      end
      if (bus.head_grant === '0) begin
         to = 1'b1;
         return;
      end
      g = bus.head_grant;
      si = bus.sel_idx;
      if (clr_ready) bus.head_ready = '0;
      while (bus.mm_rst_n === 1'b0 && rst_low < 20) begin
         rst_low++;
         bus.systolic_finish_wrap = fin_in_reset;
         cyc();
      end
      bus.systolic_finish_wrap = 1'b0;
      for (int k = 1; k <= T; k++) begin
         int gap;
         gap = int'($urandom_range(gmax, gmin));
         repeat (gap) begin
            if (bus.mm_en !== 1'b1) en_bad = 1'b1;
            cyc();
         end
         if (bus.mm_en !== 1'b1) en_bad = 1'b1;
         bus.acc_done_wrap = 1'b1;
         if (k == T && simul) bus.systolic_finish_wrap = 1'b1;
         cyc();
         bus.acc_done_wrap = 1'b0;
         bus.systolic_finish_wrap = 1'b0;
      end
      tiles = int'(bus.tile_cnt);
      if (!simul) begin
         if (bus.mm_en !== 1'b0 || bus.head_done !== '0) seq_bad = 1'b1;
         repeat (drain_gap) begin
            bus.acc_done_wrap = spurious;
            cyc();
            if (bus.tile_cnt !== CW'(T) || bus.head_done !== '0) seq_bad = 1'b1;
         end
         bus.acc_done_wrap = 1'b0;
         bus.systolic_finish_wrap = 1'b1;
         cyc();
         bus.systolic_finish_wrap = 1'b0;
      end
      lat = 1;
      while (bus.head_done === '0 && lat < 10) begin
         cyc();
         lat++;
      end
      if (bus.head_done === '0) to = 1'b1;
      done_v = bus.head_done;
      racc = racc_cnt - r0;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      cyc();
      n_tests++;
      if ({bus.head_grant, bus.sel_idx, bus.mm_rst_n, bus.mm_en,
           bus.mm_reset_acc, bus.head_done, bus.tile_cnt, bus.busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_vals: got g=%b s=%0d r=%b e=%b a=%b d=%b t=%0d b=%b expected all 0",
                  bus.head_grant, bus.sel_idx, bus.mm_rst_n, bus.mm_en,
                  bus.mm_reset_acc, bus.head_done, bus.tile_cnt, bus.busy);
      end
      rst_n = 1'b1;
      cyc();
      n_tests++;
      if (bus.mm_rst_n !== 1'b1 || bus.busy !== 1'b0 || bus.head_grant !== '0) begin
         n_fail++;
         $display("FAIL idle_vals: got r=%b b=%b g=%b expected r=1 b=0 g=0",
                  bus.mm_rst_n, bus.busy, bus.head_grant);
      end
   endtask

   task automatic test_single_head();
      logic [N-1:0] g, dv, eg;
      logic [IW-1:0] si;
      int rl, tl, ra, lat, d0, h;
      bit eb, sb, to;
      do_reset();
      bus.head_ready = 4'b0001;
      d0 = done_cnt;
      h = exp_head(4'b0001, mdl_ptr);
      eg = N'(1) << h;
      run_head(4, 4, 2, 1'b0, 1'b0, 1'b1, 1'b0,
               g, si, rl, tl, ra, dv, lat, eb, sb, to);
      mdl_ptr = (h + 1) % N;
      n_tests++;
      if (to) begin n_fail++; $display("FAIL single_timeout: got timeout expected done"); end
      n_tests++;
      if (g !== eg || si !== IW'(h)) begin
         n_fail++; $display("FAIL single_grant: got %b/%0d expected %b/%0d", g, si, eg, h);
      end
      n_tests++;
      if (rl != R) begin n_fail++; $display("FAIL single_rst_len: got %0d expected %0d", rl, R); end
      n_tests++;
      if (tl != T) begin n_fail++; $display("FAIL single_tiles: got %0d expected %0d", tl, T); end
      n_tests++;
      if (ra != T) begin n_fail++; $display("FAIL single_reset_acc: got %0d expected %0d", ra, T); end
      n_tests++;
      if (dv !== eg || lat != 1) begin
         n_fail++; $display("FAIL single_done: got %b lat %0d expected %b lat 1", dv, lat, eg);
      end
      n_tests++;
      if (eb || sb) begin n_fail++; $display("FAIL single_en: got en_bad=%0d seq_bad=%0d expected 0", eb, sb); end
      cyc();
      cyc();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.head_grant !== '0 || done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL single_idle: got busy=%b g=%b dones=%0d expected 0/0/1",
                  bus.busy, bus.head_grant, done_cnt - d0);
      end
   endtask

   task automatic test_round_robin(input int runs, input bit rnd_mask);
      logic [N-1:0] g, dv, eg, rdy;
      logic [IW-1:0] si;
      int rl, tl, ra, lat, d0, h;
      bit eb, sb, to;
      do_reset();
      d0 = done_cnt;
      rdy = '1;
      bus.head_ready = rdy;
      for (int r = 0; r < runs; r++) begin
         if (rnd_mask) begin
            rdy = N'($urandom_range((1 << N) - 1, 1));
            bus.head_ready = rdy;
         end
         h = exp_head(rdy, mdl_ptr);
         eg = N'(1) << h;
         run_head(0, 3, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                  1'b1, 1'b0, 1'b0, g, si, rl, tl, ra, dv, lat, eb, sb, to);
         mdl_ptr = (h + 1) % N;
         n_tests++;
         if (to || g !== eg || si !== IW'(h) || dv !== eg) begin
            n_fail++;
            $display("FAIL rr_run%0d: got g=%b s=%0d d=%b to=%0d expected %b/%0d",
                     r, g, si, dv, to, eg, h);
         end
         n_tests++;
         if (tl != T || ra != T || rl != R || eb || sb) begin
            n_fail++;
            $display("FAIL rr_body%0d: got t=%0d a=%0d r=%0d eb=%0d sb=%0d expected %0d/%0d/%0d/0/0",
                     r, tl, ra, rl, eb, sb, T, T, R);
         end
         cyc();
         n_tests++;
         if (bus.head_grant !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_gap%0d: got g=%b busy=%b expected 0/0", r, bus.head_grant, bus.busy);
         end
      end
      n_tests++;
      if (done_cnt - d0 != runs) begin
         n_fail++; $display("FAIL rr_done_count: got %0d expected %0d", done_cnt - d0, runs);
      end
   endtask

   task automatic test_skip_wrap();
      logic [N-1:0] g, dv;
      logic [IW-1:0] si;
      int rl, tl, ra, lat, h;
      bit eb, sb, to;
      do_reset();
      bus.head_ready = 4'b0010;
      run_head(0, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, g, si, rl, tl, ra, dv, lat, eb, sb, to);
      mdl_ptr = 2;
      cyc();
      bus.head_ready = 4'b0011;
      h = exp_head(4'b0011, mdl_ptr);
      run_head(0, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, g, si, rl, tl, ra, dv, lat, eb, sb, to);
      mdl_ptr = (h + 1) % N;
      n_tests++;
      if (to || g !== (N'(1) << h) || si !== IW'(h)) begin
         n_fail++; $display("FAIL skip_wrap: got g=%b s=%0d expected head %0d", g, si, h);
      end
   endtask

   task automatic test_simul_finish();
      logic [N-1:0] g, dv, rdy;
      logic [IW-1:0] si;
      int rl, tl, ra, lat, h, d0;
      bit eb, sb, to;
      rdy = N'($urandom_range((1 << N) - 1, 1));
      cyc();
      bus.head_ready = rdy;
      h = exp_head(rdy, mdl_ptr);
      d0 = done_cnt;
      run_head(0, 2, 0, 1'b1, 1'b0, 1'b1, 1'b1, g, si, rl, tl, ra, dv, lat, eb, sb, to);
      mdl_ptr = (h + 1) % N;
      n_tests++;
      if (to || lat != 1 || dv !== (N'(1) << h) || done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL simul_finish: got lat=%0d d=%b n=%0d expected lat 1 head %0d once",
                  lat, dv, done_cnt - d0, h);
      end
      n_tests++;
      if (rl != R || tl != T || ra != T) begin
         n_fail++; $display("FAIL simul_body: got r=%0d t=%0d a=%0d expected %0d/%0d/%0d", rl, tl, ra, R, T, T);
      end
   endtask

   task automatic test_spurious();
      logic [N-1:0] g, dv;
      logic [IW-1:0] si;
      int rl, tl, ra, lat, h, d0;
      bit eb, sb, to;
      cyc();
      bus.head_ready = 4'b1000;
      h = exp_head(4'b1000, mdl_ptr);
      run_head(1, 2, 3, 1'b0, 1'b1, 1'b1, 1'b0, g, si, rl, tl, ra, dv, lat, eb, sb, to);
      mdl_ptr = (h + 1) % N;
      n_tests++;
      if (to || sb || tl != T || ra != T || dv !== (N'(1) << h)) begin
         n_fail++;
         $display("FAIL spur_drain: got sb=%0d t=%0d a=%0d d=%b expected 0/%0d/%0d head %0d",
                  sb, tl, ra, dv, T, T, h);
      end
      cyc();
      d0 = done_cnt;
      bus.systolic_finish_wrap = 1'b1;
      repeat (4) cyc();
      bus.systolic_finish_wrap = 1'b0;
      cyc();
      n_tests++;
      if (bus.busy !== 1'b0 || bus.head_grant !== '0 || bus.mm_en !== 1'b0 ||
          done_cnt != d0) begin
         n_fail++;
         $display("FAIL spur_idle: got busy=%b g=%b en=%b dones=%0d expected 0/0/0/0",
                  bus.busy, bus.head_grant, bus.mm_en, done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [N-1:0] g, dv;
      logic [IW-1:0] si;
      int rl, tl, ra, lat, h, d0, w;
      bit eb, sb, to;
      do_reset();
      bus.head_ready = 4'b0010;
      run_head(0, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, g, si, rl, tl, ra, dv, lat, eb, sb, to);
      mdl_ptr = 2;
      cyc();
      bus.head_ready = 4'b1111;
      h = exp_head(4'b1111, mdl_ptr);
      w = 0;
      while (bus.mm_en !== 1'b1 && w < 20) begin cyc(); w++; end
      n_tests++;
      if (bus.mm_en !== 1'b1 || bus.head_grant !== (N'(1) << h)) begin
         n_fail++; $display("FAIL mid_start: got en=%b g=%b expected 1 head %0d", bus.mm_en, bus.head_grant, h);
      end
      repeat (3) begin
         bus.acc_done_wrap = 1'b1;
         cyc();
         bus.acc_done_wrap = 1'b0;
         cyc();
      end
      n_tests++;
      if (bus.tile_cnt !== CW'(3)) begin
         n_fail++; $display("FAIL mid_tiles: got %0d expected 3", bus.tile_cnt);
      end
      d0 = done_cnt;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      mdl_ptr = 0;
      n_tests++;
      if ({bus.head_grant, bus.sel_idx, bus.mm_rst_n, bus.mm_en,
           bus.mm_reset_acc, bus.head_done, bus.tile_cnt, bus.busy} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_vals: got g=%b s=%0d r=%b e=%b t=%0d b=%b expected all 0",
                  bus.head_grant, bus.sel_idx, bus.mm_rst_n, bus.mm_en, bus.tile_cnt, bus.busy);
      end
      h = exp_head(4'b1111, mdl_ptr);
      run_head(0, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, g, si, rl, tl, ra, dv, lat, eb, sb, to);
      mdl_ptr = (h + 1) % N;
      n_tests++;
      if (to || g !== (N'(1) << h) || done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL mid_regrant: got g=%b dones=%0d expected head %0d and 1 done", g, done_cnt - d0, h);
      end
   endtask

   initial begin
      test_reset();
      test_single_head();
      test_round_robin(5, 1'b0);
      test_round_robin(6, 1'b1);
      test_skip_wrap();
      test_simul_finish();
      test_spurious();
      test_reset_mid_run();
      n_tests++;
      if (inv_bad != 0) begin
         n_fail++; $display("FAIL invariants: got %0d violations expected 0", inv_bad);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
